// File: rtl/axi_dma_lite_regs.sv
`default_nettype none
// ============================================================================
// Module      : axi_dma_lite_regs
// Description : AXI-Lite slave for the simple-mode AXI DMA register view
//               (MM2S/S2MM DMACR, DMASR, address, LENGTH) with per-channel
//               start/done command ports toward a datamover model.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_dma_lite_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 26
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_lite_awaddr,
    input  logic [2:0]            s_axi_lite_awprot,
    input  logic                  s_axi_lite_awvalid,
    output logic                  s_axi_lite_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_lite_wdata,
    input  logic [3:0]            s_axi_lite_wstrb,
    input  logic                  s_axi_lite_wvalid,
    output logic                  s_axi_lite_wready,
    output logic [1:0]            s_axi_lite_bresp,
    output logic                  s_axi_lite_bvalid,
    input  logic                  s_axi_lite_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_lite_araddr,
    input  logic [2:0]            s_axi_lite_arprot,
    input  logic                  s_axi_lite_arvalid,
    output logic                  s_axi_lite_arready,
    output logic [DATA_WIDTH-1:0] s_axi_lite_rdata,
    output logic [1:0]            s_axi_lite_rresp,
    output logic                  s_axi_lite_rvalid,
    input  logic                  s_axi_lite_rready,
    output logic                  mm2s_start,
    output logic [31:0]           mm2s_addr,
    output logic [LEN_WIDTH-1:0]  mm2s_len,
    input  logic                  mm2s_done,
    output logic                  mm2s_introut,
    output logic                  s2mm_start,
    output logic [31:0]           s2mm_addr,
    output logic [LEN_WIDTH-1:0]  s2mm_len,
    input  logic                  s2mm_done,
    output logic                  s2mm_introut
);

    localparam logic [6:0] c_OFF_DMACR = 7'h00;
    localparam logic [6:0] c_OFF_DMASR = 7'h04;
    localparam logic [6:0] c_OFF_ADDR  = 7'h18;
    localparam logic [6:0] c_OFF_LEN   = 7'h28;

    logic                  r_aw_held;
    logic [6:0]            r_aw_addr;
    logic                  r_w_held;
    logic [31:0]           r_w_data;
    logic [3:0]            r_w_strb;
    logic                  r_bvalid;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic [6:0]            w_wr_addr;
    logic [31:0]           w_wr_data;
    logic [3:0]            w_wr_strb;
    logic                  w_commit;
    logic                  w_wr_en;
    logic [31:0]           w_rd_data;
    logic                  w_unused;

    logic [1:0]                w_done;
    logic [1:0]                w_start;
    logic [1:0][31:0]          w_start_addr;
    logic [1:0][LEN_WIDTH-1:0] w_start_len;
    logic [1:0]                w_intr;
    logic [1:0][31:0]          w_cr;
    logic [1:0][31:0]          w_sr;
    logic [1:0][31:0]          w_addr;
    logic [1:0][31:0]          w_len;

    assign w_unused = ^{s_axi_lite_awaddr[ADDR_WIDTH-1:7], s_axi_lite_awprot,
                        s_axi_lite_araddr[ADDR_WIDTH-1:7], s_axi_lite_arprot};

    assign s_axi_lite_awready = ~r_aw_held & ~r_bvalid;
    assign s_axi_lite_wready  = ~r_w_held & ~r_bvalid;
    assign s_axi_lite_arready = ~r_rvalid;
    assign s_axi_lite_bvalid  = r_bvalid;
    assign s_axi_lite_bresp   = 2'b00;
    assign s_axi_lite_rvalid  = r_rvalid;
    assign s_axi_lite_rresp   = 2'b00;
    assign s_axi_lite_rdata   = r_rdata;

    assign w_aw_hs = s_axi_lite_awvalid & s_axi_lite_awready;
    assign w_w_hs  = s_axi_lite_wvalid & s_axi_lite_wready;
    assign w_ar_hs = s_axi_lite_arvalid & s_axi_lite_arready;

    // A held beat takes priority; otherwise the beat handshaking this cycle is used.
    assign w_wr_addr = r_aw_held ? r_aw_addr : s_axi_lite_awaddr[6:0];
    assign w_wr_data = r_w_held  ? r_w_data  : s_axi_lite_wdata;
    assign w_wr_strb = r_w_held  ? r_w_strb  : s_axi_lite_wstrb;
    assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_wr_en   = w_commit & (w_wr_strb == 4'hF);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= s_axi_lite_awaddr[6:0];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= s_axi_lite_wdata;
                    r_w_strb <= s_axi_lite_wstrb;
                end
                if (r_bvalid && s_axi_lite_bready) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    assign w_done = {s2mm_done, mm2s_done};

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        localparam logic [6:0] c_BASE = (gi == 0) ? 7'h00 : 7'h30;
        localparam logic [6:0] c_A_CR = 7'(c_BASE + c_OFF_DMACR);
        localparam logic [6:0] c_A_SR = 7'(c_BASE + c_OFF_DMASR);
        localparam logic [6:0] c_A_AD = 7'(c_BASE + c_OFF_ADDR);
        localparam logic [6:0] c_A_LN = 7'(c_BASE + c_OFF_LEN);

        logic                 r_rs;
        logic                 r_ioc_en;
        logic                 r_busy;
        logic                 r_idle;
        logic                 r_ioc;
        logic                 r_start;
        logic                 r_intr;
        logic [31:0]          r_addr;
        logic [31:0]          r_start_addr;
        logic [LEN_WIDTH-1:0] r_len;
        logic [LEN_WIDTH-1:0] r_start_len;

        logic w_wr_cr;
        logic w_wr_sr;
        logic w_wr_ad;
        logic w_wr_ln;
        logic w_done_eff;
        logic w_busy_pre;
        logic w_launch;
        logic w_w1c;

        assign w_wr_cr    = w_wr_en & (w_wr_addr == c_A_CR);
        assign w_wr_sr    = w_wr_en & (w_wr_addr == c_A_SR);
        assign w_wr_ad    = w_wr_en & (w_wr_addr == c_A_AD);
        assign w_wr_ln    = w_wr_en & (w_wr_addr == c_A_LN);
        assign w_done_eff = w_done[gi] & r_busy;
        // Completion on the same edge frees the channel for a new launch.
        assign w_busy_pre = r_busy & ~w_done[gi];
        assign w_launch   = w_wr_ln & r_rs & ~w_busy_pre
                          & (w_wr_data[LEN_WIDTH-1:0] != '0);
        assign w_w1c      = w_wr_sr & w_wr_data[12];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_rs         <= 1'b0;
                r_ioc_en     <= 1'b0;
                r_busy       <= 1'b0;
                r_idle       <= 1'b0;
                r_ioc        <= 1'b0;
                r_start      <= 1'b0;
                r_intr       <= 1'b0;
                r_addr       <= '0;
                r_start_addr <= '0;
                r_len        <= '0;
                r_start_len  <= '0;
            end else begin
                r_start <= w_launch;
                r_intr  <= r_ioc & r_ioc_en;
                if (w_wr_cr) begin
                    r_rs     <= w_wr_data[0];
                    r_ioc_en <= w_wr_data[12];
                end
                if (w_wr_ad) begin
                    r_addr <= w_wr_data;
                end
                if (w_wr_ln) begin
                    r_len <= w_wr_data[LEN_WIDTH-1:0];
                end
                if (w_launch) begin
                    r_busy       <= 1'b1;
                    r_idle       <= 1'b0;
                    r_start_addr <= r_addr;
                    r_start_len  <= w_wr_data[LEN_WIDTH-1:0];
                end else if (w_done_eff) begin
                    r_busy <= 1'b0;
                    r_idle <= 1'b1;
                end
                // Completion outranks a simultaneous write-1-to-clear.
                if (w_done_eff) begin
                    r_ioc <= 1'b1;
                end else if (w_w1c) begin
                    r_ioc <= 1'b0;
                end
            end
        end

        assign w_start[gi]      = r_start;
        assign w_start_addr[gi] = r_start_addr;
        assign w_start_len[gi]  = r_start_len;
        assign w_intr[gi]       = r_intr;
        assign w_cr[gi]         = {19'd0, r_ioc_en, 11'd0, r_rs};
        assign w_sr[gi]         = {19'd0, r_ioc, 10'd0, r_idle, ~r_rs & ~r_busy};
        assign w_addr[gi]       = r_addr;
        assign w_len[gi]        = 32'(r_len);
    end

    assign mm2s_start   = w_start[0];
    assign mm2s_addr    = w_start_addr[0];
    assign mm2s_len     = w_start_len[0];
    assign mm2s_introut = w_intr[0];
    assign s2mm_start   = w_start[1];
    assign s2mm_addr    = w_start_addr[1];
    assign s2mm_len     = w_start_len[1];
    assign s2mm_introut = w_intr[1];

    always_comb begin
        w_rd_data = 32'd0;
        case (s_axi_lite_araddr[6:0])
            7'h00:   w_rd_data = w_cr[0];
            7'h04:   w_rd_data = w_sr[0];
            7'h18:   w_rd_data = w_addr[0];
            7'h28:   w_rd_data = w_len[0];
            7'h30:   w_rd_data = w_cr[1];
            7'h34:   w_rd_data = w_sr[1];
            7'h48:   w_rd_data = w_addr[1];
            7'h58:   w_rd_data = w_len[1];
            default: w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (r_rvalid && s_axi_lite_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_dma_lite_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_dma_lite_regs
// Description : Directed self-checking bench for axi_dma_lite_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_dma_lite_regs;

    localparam int c_LW = 26;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [31:0]     awaddr = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [31:0]     araddr = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b0;
    logic            mm2s_start;
    logic [31:0]     mm2s_addr;
    logic [c_LW-1:0] mm2s_len;
    logic            mm2s_done = 1'b0;
    logic            mm2s_introut;
    logic            s2mm_start;
    logic [31:0]     s2mm_addr;
    logic [c_LW-1:0] s2mm_len;
    logic            s2mm_done = 1'b0;
    logic            s2mm_introut;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mm2s_starts = 0;
    int          s2mm_starts = 0;
    logic [31:0] mm2s_seen_addr = '0;
    logic [31:0] mm2s_seen_len  = '0;
    logic [31:0] s2mm_seen_addr = '0;
    logic [31:0] s2mm_seen_len  = '0;
    logic [31:0] rd;

    axi_dma_lite_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(c_LW)) u_dut (
        .clk                (clk),
        .resetn             (resetn),
        .s_axi_lite_awaddr  (awaddr),
        .s_axi_lite_awprot  (3'b000),
        .s_axi_lite_awvalid (awvalid),
        .s_axi_lite_awready (awready),
        .s_axi_lite_wdata   (wdata),
        .s_axi_lite_wstrb   (wstrb),
        .s_axi_lite_wvalid  (wvalid),
        .s_axi_lite_wready  (wready),
        .s_axi_lite_bresp   (bresp),
        .s_axi_lite_bvalid  (bvalid),
        .s_axi_lite_bready  (bready),
        .s_axi_lite_araddr  (araddr),
        .s_axi_lite_arprot  (3'b000),
        .s_axi_lite_arvalid (arvalid),
        .s_axi_lite_arready (arready),
        .s_axi_lite_rdata   (rdata),
        .s_axi_lite_rresp   (rresp),
        .s_axi_lite_rvalid  (rvalid),
        .s_axi_lite_rready  (rready),
        .mm2s_start         (mm2s_start),
        .mm2s_addr          (mm2s_addr),
        .mm2s_len           (mm2s_len),
        .mm2s_done          (mm2s_done),
        .mm2s_introut       (mm2s_introut),
        .s2mm_start         (s2mm_start),
        .s2mm_addr          (s2mm_addr),
        .s2mm_len           (s2mm_len),
        .s2mm_done          (s2mm_done),
        .s2mm_introut       (s2mm_introut)
    );

    always #5 clk = ~clk;

    // A start pulse spans exactly one negedge, so a stuck pulse inflates the count.
    always @(negedge clk) begin
        if (mm2s_start) begin
            mm2s_starts    <= mm2s_starts + 1;
            mm2s_seen_addr <= mm2s_addr;
            mm2s_seen_len  <= 32'(mm2s_len);
        end
        if (s2mm_start) begin
            s2mm_starts    <= s2mm_starts + 1;
            s2mm_seen_addr <= s2mm_addr;
            s2mm_seen_len  <= 32'(s2mm_len);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_fire;
        bit w_fire;
        int k;
        for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
            @(negedge clk);
            awaddr  = {25'd0, addr};
            wdata   = data;
            wstrb   = strb;
            awvalid = (cyc >= aw_dly) && !aw_done;
            wvalid  = (cyc >= w_dly) && !w_done;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk);
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) check_eq("wr_handshake_timeout", 32'd0, 32'd1);
        for (int i = 0; i < b_dly; i++) begin
            check_eq("bvalid_held", 32'(bvalid), 32'd1);
            check_eq("awready_blocked", 32'(awready), 32'd0);
            check_eq("wready_blocked", 32'(wready), 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        k = 0;
        while (!bvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bvalid) check_eq("bvalid_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        if (b_dly > 0) check_eq("single_b", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [6:0] addr, output logic [31:0] data);
        int k = 0;
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = {25'd0, addr};
        while (!arready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        rready  = 1'b1;
        k = 0;
        while (!rvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!rvalid) check_eq("rvalid_timeout", 32'd0, 32'd1);
        data = rdata;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic pulse_done(input bit s2mm);
        @(negedge clk);
        if (s2mm) s2mm_done = 1'b1;
        else      mm2s_done = 1'b1;
        @(negedge clk);
        mm2s_done = 1'b0;
        s2mm_done = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_awready", 32'(awready), 32'd1);
        check_eq("rst_wready", 32'(wready), 32'd1);
        check_eq("rst_arready", 32'(arready), 32'd1);
        check_eq("rst_bvalid", 32'(bvalid), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_mm2s_start", 32'(mm2s_start), 32'd0);
        check_eq("rst_introut", 32'({mm2s_introut, s2mm_introut}), 32'd0);
        resetn = 1'b1;

        axi_read(7'h04, rd); check_eq("mm2s_sr_reset", rd, 32'h0000_0001);
        axi_read(7'h34, rd); check_eq("s2mm_sr_reset", rd, 32'h0000_0001);
        axi_read(7'h10, rd); check_eq("unmapped_read", rd, 32'h0000_0000);

        // MM2S configure and launch
        axi_write(7'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_read(7'h00, rd); check_eq("mm2s_cr_bits", rd, 32'h0000_1001);
        axi_write(7'h18, 32'h1000_0000, 4'hF, 0, 0, 0);
        axi_write(7'h18, 32'hDEAD_BEEF, 4'h3, 0, 0, 0);
        axi_read(7'h18, rd); check_eq("partial_strobe_ignored", rd, 32'h1000_0000);
        axi_write(7'h28, 32'h0000_0100, 4'hF, 0, 0, 0);
        check_eq("mm2s_start_count", 32'(mm2s_starts), 32'd1);
        check_eq("mm2s_start_addr", mm2s_seen_addr, 32'h1000_0000);
        check_eq("mm2s_start_len", mm2s_seen_len, 32'h0000_0100);
        axi_read(7'h04, rd); check_eq("mm2s_sr_busy", rd, 32'h0000_0000);
        axi_write(7'h28, 32'h0000_0200, 4'hF, 0, 0, 0);
        check_eq("no_launch_while_busy", 32'(mm2s_starts), 32'd1);
        axi_read(7'h28, rd); check_eq("mm2s_len_readback", rd, 32'h0000_0200);

        // Completion sets Idle/IOC, interrupt one cycle later
        @(negedge clk);
        mm2s_done = 1'b1;
        @(negedge clk);
        mm2s_done = 1'b0;
        check_eq("introut_latency0", 32'(mm2s_introut), 32'd0);
        @(negedge clk);
        check_eq("introut_latency1", 32'(mm2s_introut), 32'd1);
        axi_read(7'h04, rd); check_eq("mm2s_sr_done", rd, 32'h0000_1002);
        axi_write(7'h04, 32'h0000_1000, 4'hF, 0, 0, 0);
        axi_read(7'h04, rd); check_eq("mm2s_sr_w1c", rd, 32'h0000_0002);
        check_eq("mm2s_introut_cleared", 32'(mm2s_introut), 32'd0);
        pulse_done(1'b0);
        axi_read(7'h04, rd); check_eq("done_while_idle", rd, 32'h0000_0002);

        // S2MM: no launch with RS=0 or zero length
        axi_write(7'h58, 32'h0000_0040, 4'hF, 0, 0, 0);
        check_eq("s2mm_no_start_rs0", 32'(s2mm_starts), 32'd0);
        axi_read(7'h34, rd); check_eq("s2mm_sr_rs0", rd, 32'h0000_0001);
        axi_read(7'h58, rd); check_eq("s2mm_len_40", rd, 32'h0000_0040);
        axi_write(7'h58, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_read(7'h58, rd); check_eq("s2mm_len_mask", rd, 32'h03FF_FFFF);
        axi_write(7'h30, 32'h0000_0001, 4'hF, 0, 0, 0);
        axi_write(7'h58, 32'h0000_0000, 4'hF, 0, 0, 0);
        check_eq("s2mm_no_start_len0", 32'(s2mm_starts), 32'd0);
        axi_read(7'h34, rd); check_eq("s2mm_sr_running", rd, 32'h0000_0000);

        // Skewed AW/W with back-pressured B
        axi_write(7'h48, 32'hA000_0000, 4'hF, 0, 3, 2);
        axi_write(7'h58, 32'h0000_0080, 4'hF, 3, 0, 2);
        check_eq("s2mm_start_count", 32'(s2mm_starts), 32'd1);
        check_eq("s2mm_start_addr", s2mm_seen_addr, 32'hA000_0000);
        check_eq("s2mm_start_len", s2mm_seen_len, 32'h0000_0080);
        check_eq("mm2s_untouched", 32'(mm2s_starts), 32'd1);
        pulse_done(1'b1);
        axi_read(7'h34, rd); check_eq("s2mm_sr_done", rd, 32'h0000_1002);
        check_eq("s2mm_introut_disabled", 32'(s2mm_introut), 32'd0);

        // Done and W1C on the same edge: set wins
        axi_write(7'h28, 32'h0000_0020, 4'hF, 0, 0, 0);
        check_eq("mm2s_second_start", 32'(mm2s_starts), 32'd2);
        check_eq("mm2s_second_len", mm2s_seen_len, 32'h0000_0020);
        @(negedge clk);
        awaddr = 32'h04; wdata = 32'h0000_1000; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; mm2s_done = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; mm2s_done = 1'b0;
        check_eq("w1c_done_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        axi_read(7'h04, rd); check_eq("ioc_set_wins", rd, 32'h0000_1002);

        // Reset with a read response pending
        @(negedge clk);
        araddr = 32'h04; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("rvalid_pending", 32'(rvalid), 32'd1);
        resetn = 1'b0;
        #1;
        check_eq("rvalid_dropped", 32'(rvalid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        axi_read(7'h04, rd); check_eq("sr_after_reset", rd, 32'h0000_0001);
        axi_read(7'h00, rd); check_eq("cr_after_reset", rd, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
